// File: rtl/rom_arbiter.sv
// Round-robin arbiter granting two requesters single-word reads from a ROM.
// One transaction is outstanding at a time; out-of-range addresses get an error response.
module rom_arbiter #(
    parameter int ROM_DEPTH = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [15:0] req0_address,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [15:0] req1_address,
    output logic        req1_ready,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_error,
    output logic        rom_read_enable,
    output logic [15:0] rom_address,
    input  logic [15:0] rom_read_data
);

    typedef enum logic [1:0] {IDLE, READ, LATCH, RESP} state_e;

    // A 17-bit bound keeps the range check valid for any depth up to 65536.
    localparam logic [16:0] DEPTH_BOUND = 17'(ROM_DEPTH);

    state_e      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic        id_q, id_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        error_q, error_d;

    logic        grant_valid;
    logic        grant_id;
    logic [15:0] grant_addr;

    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        id_d            = id_q;
        addr_d          = addr_q;
        data_d          = data_q;
        error_d         = error_q;
        grant_valid     = 1'b0;
        grant_id        = 1'b0;
        grant_addr      = req0_address;
        req0_ready      = 1'b0;
        req1_ready      = 1'b0;
        rom_read_enable = 1'b0;
        rsp_valid       = 2'b00;

        case (state_q)
            IDLE: begin
                if (req0_valid && req1_valid) begin
                    grant_valid = 1'b1;
                    grant_id    = ptr_q;
                end else if (req0_valid || req1_valid) begin
                    grant_valid = 1'b1;
                    grant_id    = req1_valid;
                end
                grant_addr = grant_id ? req1_address : req0_address;

                // Nothing is accepted while reset is held low.
                if (grant_valid && reset) begin
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    ptr_d      = ~grant_id;
                    id_d       = grant_id;
                    addr_d     = grant_addr;
                    if ({1'b0, grant_addr} < DEPTH_BOUND) begin
                        state_d = READ;
                    end else begin
                        data_d  = 16'h0000;
                        error_d = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            READ: begin
                rom_read_enable = 1'b1;
                state_d         = LATCH;
            end
            LATCH: begin
                data_d  = rom_read_data;
                error_d = 1'b0;
                state_d = RESP;
            end
            RESP: begin
                rsp_valid = id_q ? 2'b10 : 2'b01;
                if (rsp_ready[id_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments; reset is synchronous and active-low.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            id_q    <= 1'b0;
            addr_q  <= 16'h0000;
            data_q  <= 16'h0000;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            error_q <= error_d;
        end
    end

    assign rom_address = addr_q;
    assign rsp_data    = data_q;
    assign rsp_error   = error_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Scoreboard bench for rom_arbiter: a timing-level reference model predicts grants,
// ROM reads and responses; a separate monitor checks every presented response.
module tb_rom_arbiter;

    localparam int ROM_DEPTH = 256;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req0_valid = 1'b0;
    logic [15:0] req0_address = 16'h0000;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [15:0] req1_address = 16'h0000;
    logic        req1_ready;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = 2'b00;
    logic [15:0] rsp_data;
    logic        rsp_error;
    logic        rom_read_enable;
    logic [15:0] rom_address;
    logic [15:0] rom_read_data = 16'h0000;

    rom_arbiter #(.ROM_DEPTH(ROM_DEPTH)) dut (
        .clock           (clock),
        .reset           (reset),
        .req0_valid      (req0_valid),
        .req0_address    (req0_address),
        .req0_ready      (req0_ready),
        .req1_valid      (req1_valid),
        .req1_address    (req1_address),
        .req1_ready      (req1_ready),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_data        (rsp_data),
        .rsp_error       (rsp_error),
        .rom_read_enable (rom_read_enable),
        .rom_address     (rom_address),
        .rom_read_data   (rom_read_data)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] rom_f(input logic [15:0] a);
        logic [15:0] r;
        r = 16'(a * 16'd40503) ^ 16'h3C3C;
        if (a == 16'h0005) r = 16'hBEEF;
        return r;
    endfunction

    // ROM: data valid only the cycle after a read, otherwise noise.
    always @(posedge clock) begin
        if (rom_read_enable) rom_read_data <= rom_f(rom_address);
        else                 rom_read_data <= 16'($urandom);
    end

    typedef struct packed {
        logic [1:0]  valid;
        logic [15:0] data;
        logic        error;
    } rsp_t;

    rsp_t sbq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // Reference model state
    bit          busy = 1'b0;
    bit          ptr = 1'b0;
    bit          resp_id = 1'b0;
    bit          resp_inrng = 1'b0;
    int          resp_at = 0;
    logic [15:0] last_addr = 16'h0000;
    bit          prev_rst = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic step(input logic v0, input logic [15:0] a0, input logic v1,
                        input logic [15:0] a1, input logic [1:0] rr, input logic rst);
        bit          g_valid;
        bit          g_id;
        logic [15:0] g_addr;
        logic [1:0]  e_rv;
        bit          e_re;
        bit          inrng;
        rsp_t        e;
        @(negedge clock);
        req0_valid = v0; req0_address = a0;
        req1_valid = v1; req1_address = a1;
        rsp_ready = rr; reset = rst;
        #1;
        g_valid = v0 || v1;
        g_id    = (v0 && v1) ? ptr : v1;
        g_addr  = g_id ? a1 : a0;
        e_rv    = (busy && cyc >= resp_at) ? (resp_id ? 2'b10 : 2'b01) : 2'b00;
        e_re    = busy && resp_inrng && (cyc == resp_at - 2);
        if (chk_en) begin
            check("req0_ready", 32'(req0_ready), 32'(rst && !busy && g_valid && !g_id));
            check("req1_ready", 32'(req1_ready), 32'(rst && !busy && g_valid && g_id));
            check("rsp_valid", 32'(rsp_valid), 32'(e_rv));
            check("rom_read_enable", 32'(rom_read_enable), 32'(e_re));
            check("rom_address", 32'(rom_address), 32'(last_addr));
            if (!prev_rst) begin
                check("reset_rsp_data", 32'(rsp_data), 32'h0);
                check("reset_rsp_error", 32'(rsp_error), 32'h0);
            end
        end
        if (!rst) begin
            if (busy && cyc < resp_at) sbq.delete(sbq.size() - 1);
            busy = 1'b0; ptr = 1'b0; last_addr = 16'h0000;
        end else if (busy) begin
            if (cyc >= resp_at && rr[resp_id]) busy = 1'b0;
        end else if (g_valid) begin
            inrng      = int'(g_addr) < ROM_DEPTH;
            busy       = 1'b1;
            ptr        = ~g_id;
            resp_id    = g_id;
            resp_inrng = inrng;
            resp_at    = cyc + (inrng ? 3 : 1);
            last_addr  = g_addr;
            e.valid    = g_id ? 2'b10 : 2'b01;
            e.data     = inrng ? rom_f(g_addr) : 16'h0000;
            e.error    = !inrng;
            sbq.push_back(e);
        end
        prev_rst = rst;
        cyc++;
    endtask

    // Monitor: pops one expectation per presented response, holds it until handshake.
    bit   have_cur = 1'b0;
    rsp_t cur;
    initial begin
        forever begin
            @(negedge clock);
            #2;
            if (chk_en && rsp_valid !== 2'b00) begin
                if (!have_cur) begin
                    if (sbq.size() == 0) begin
                        check("unexpected_rsp_valid", 32'(rsp_valid), 32'h0);
                    end else begin
                        cur = sbq.pop_front();
                        have_cur = 1'b1;
                    end
                end
                if (have_cur) begin
                    check("sb_rsp_valid", 32'(rsp_valid), 32'(cur.valid));
                    check("sb_rsp_data", 32'(rsp_data), 32'(cur.data));
                    check("sb_rsp_error", 32'(rsp_error), 32'(cur.error));
                    if (((rsp_valid & rsp_ready) != 2'b00) || !reset) have_cur = 1'b0;
                end
            end else begin
                have_cur = 1'b0;
            end
        end
    end

    function automatic logic [15:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return 16'($urandom_range(0, 255));
            1:       return ($urandom_range(0, 1) == 0) ? 16'h00FF : 16'h0100;
            2:       return 16'($urandom);
            default: return 16'h0005;
        endcase
    endfunction

    initial begin
        repeat (2) @(posedge clock);
        chk_en = 1'b1;
        step(0, 16'h0, 0, 16'h0, 2'b11, 0);

        // Single in-range read of 0x0005
        step(1, 16'h0005, 0, 16'h0, 2'b11, 1);
        repeat (4) step(0, 16'h0, 0, 16'h0, 2'b11, 1);

        // Out-of-range read by requester 1
        step(0, 16'h0, 1, 16'h0100, 2'b11, 1);
        repeat (3) step(0, 16'h0, 0, 16'h0, 2'b11, 1);

        // Back-pressure, non-owning ready ignored, then release
        step(1, 16'h0007, 0, 16'h0, 2'b00, 1);
        repeat (3) step(1, 16'h0009, 1, 16'h0002, 2'b00, 1);
        repeat (5) step(1, 16'h0009, 1, 16'h0002, 2'b00, 1);
        repeat (5) step(1, 16'h0009, 1, 16'h0002, 2'b10, 1);
        step(0, 16'h0, 0, 16'h0, 2'b01, 1);
        step(0, 16'h0, 0, 16'h0, 2'b00, 1);

        // Alternating grants from reset with both requesters busy
        step(0, 16'h0, 0, 16'h0, 2'b11, 0);
        repeat (16) step(1, 16'h0010, 1, 16'h0020, 2'b11, 1);
        repeat (4) step(0, 16'h0, 0, 16'h0, 2'b11, 1);

        // Reset while the ROM read is in flight
        step(1, 16'h0030, 0, 16'h0, 2'b11, 1);
        step(0, 16'h0, 0, 16'h0, 2'b11, 0);
        step(1, 16'h0005, 1, 16'h0006, 2'b11, 1);
        repeat (4) step(0, 16'h0, 0, 16'h0, 2'b11, 1);

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            step(1'($urandom_range(0, 1)), rand_addr(), 1'($urandom_range(0, 1)), rand_addr(),
                 ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b11,
                 ($urandom_range(0, 149) != 0));
        end

        // Drain
        repeat (8) step(0, 16'h0, 0, 16'h0, 2'b11, 1);
        @(negedge clock);
        #3;
        check("scoreboard_empty", 32'(sbq.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
